axis_rx_dst_filter: RTL



---
 rtl/axis_rx_dst_filter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/axis_rx_dst_filter.sv
// Rx destination-MAC filter: forwards local/broadcast (or all, in promiscuous mode) frames
// through a one-stage output slice and drops the rest whole. Optional macro: RX_DST_FILTER_MCAST_EN.
module axis_rx_dst_filter #(
  parameter logic [47:0] LOCAL_MAC = 48'h000000000000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               promisc,
  input  logic [63:0]        s_axis_tdata,
  input  logic [7:0]         s_axis_tstrb,
  input  logic [127:0]       s_axis_tuser,
  input  logic               s_axis_tvalid,
  input  logic               s_axis_tlast,
  output logic               s_axis_tready,
  output logic [63:0]        m_axis_tdata,
  output logic [7:0]         m_axis_tstrb,
  output logic [127:0]       m_axis_tuser,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  input  logic               m_axis_tready,
  output logic [CNT_W-1:0]   fwd_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = 8;
  localparam int unsigned USER_W = 128;
  localparam int unsigned MAC_W  = 48;

  typedef enum logic [1:0] {S_HEAD, S_FWD, S_DROP} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   tdata_q;
  logic [STRB_W-1:0]   tstrb_q;
  logic [USER_W-1:0]   tuser_q;
  logic                tvalid_q;
  logic                tlast_q;
  logic [CNT_W-1:0]    fwd_cnt_q;
  logic [CNT_W-1:0]    drop_cnt_q;

  logic [MAC_W-1:0]    dst;
  logic                mcast_hit;
  logic                pass;
  logic                runt;
  logic                keep;
  logic                out_free;
  logic                accept;
  logic                head_beat;
  logic                fwd_beat;

  assign dst = s_axis_tdata[MAC_W-1:0];

`ifdef RX_DST_FILTER_MCAST_EN
  assign mcast_hit = dst[0];
`else
  assign mcast_hit = 1'b0;
`endif

  assign pass = promisc | mcast_hit | (dst == LOCAL_MAC) | (dst == {MAC_W{1'b1}});
  // A first beat must carry the whole destination address, otherwise it is a runt.
  assign runt = (s_axis_tstrb[5:0] != 6'h3F);
  assign keep = pass & ~runt;

  assign out_free      = ~tvalid_q | m_axis_tready;
  assign s_axis_tready = (state_q == S_DROP) | out_free;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign head_beat     = accept & (state_q == S_HEAD);
  assign fwd_beat      = accept & ((state_q == S_FWD) | ((state_q == S_HEAD) & keep));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_HEAD;
      tdata_q    <= '0;
      tstrb_q    <= '0;
      tuser_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      // Output slice: load on a forwarded beat, otherwise drain when taken downstream.
      if (fwd_beat) begin
        tdata_q  <= s_axis_tdata;
        tstrb_q  <= s_axis_tstrb;
        tuser_q  <= s_axis_tuser;
        tlast_q  <= s_axis_tlast;
        tvalid_q <= 1'b1;
      end else if (m_axis_tready) begin
        tvalid_q <= 1'b0;
      end

      if (head_beat) begin
        if (keep) fwd_cnt_q  <= fwd_cnt_q + CNT_W'(1);
        else      drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end

      if (accept) begin
        case (state_q)
          S_HEAD: begin
            if (!s_axis_tlast) state_q <= keep ? S_FWD : S_DROP;
          end
          S_FWD, S_DROP: begin
            if (s_axis_tlast) state_q <= S_HEAD;
          end
          default: state_q <= S_HEAD;
        endcase
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tstrb  = tstrb_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign fwd_cnt       = fwd_cnt_q;
  assign drop_cnt      = drop_cnt_q;

endmodule
